// File: rtl/score_keeper_pkg.sv
// ============================================================================
// score_keeper_pkg : match state encoding, winner codes, default limits
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

package score_keeper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PLAYING = 2'd1,
        ST_OVER    = 2'd2
    } state_e;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_P1   = 2'b01;
    localparam logic [1:0] WINNER_P2   = 2'b10;
    localparam logic [1:0] WINNER_TIE  = 2'b11;

    localparam int unsigned DEF_MAX_SCORE = 999;
    localparam int unsigned DEF_WIN_SCORE = 100;

endpackage

`default_nettype wire

// File: rtl/score_keeper_edge.sv
// ============================================================================
// rise_edge_det : registered one-cycle pulse on a 0->1 transition of sig_i
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module rise_edge_det (
    input  logic clk,
    input  logic reset,
    input  logic sig_i,
    output logic edge_o
);

    logic prev_q;
    logic edge_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
            edge_q <= sig_i & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

`default_nettype wire

// File: rtl/score_keeper.sv
// ============================================================================
// score_keeper : match FSM and saturating per-player score accumulators
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module score_keeper
    import score_keeper_pkg::*;
#(
    parameter int unsigned SCORE_W   = 10,
    parameter int unsigned MAX_SCORE = DEF_MAX_SCORE,
    parameter int unsigned WIN_SCORE = DEF_WIN_SCORE,
    parameter int unsigned PTS_W     = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               hit_p1,
    input  logic               hit_p2,
    input  logic [PTS_W-1:0]   pts_p1,
    input  logic [PTS_W-1:0]   pts_p2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               playing,
    output logic               game_over,
    output logic [1:0]         winner,
    output logic               score_upd
);

    localparam logic [SCORE_W:0]   C_MAX_EXT = (SCORE_W+1)'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] C_MAX     = SCORE_W'(MAX_SCORE);
    localparam logic [SCORE_W-1:0] C_WIN     = SCORE_W'(WIN_SCORE);
    localparam logic               C_WIN_EN  = (WIN_SCORE != 0);

    state_e             state_q, state_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [1:0]         winner_q, winner_d;
    logic               upd_q;
    logic [PTS_W-1:0]   pts1_q, pts2_q;

    logic               w_start_ev, w_hit1_ev, w_hit2_ev;
    logic [SCORE_W:0]   w_sum1, w_sum2;
    logic [SCORE_W-1:0] w_sat1, w_sat2;
    logic               w_p1_win, w_p2_win;

    rise_edge_det u_start_det (.clk(clk), .reset(reset), .sig_i(start),  .edge_o(w_start_ev));
    rise_edge_det u_hit1_det  (.clk(clk), .reset(reset), .sig_i(hit_p1), .edge_o(w_hit1_ev));
    rise_edge_det u_hit2_det  (.clk(clk), .reset(reset), .sig_i(hit_p2), .edge_o(w_hit2_ev));

    // Points are captured on the same edge that registers the hit pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            pts1_q <= '0;
            pts2_q <= '0;
        end else begin
            pts1_q <= pts_p1;
            pts2_q <= pts_p2;
        end
    end

    assign w_sum1 = {1'b0, score1_q} + {{(SCORE_W+1-PTS_W){1'b0}}, pts1_q};
    assign w_sum2 = {1'b0, score2_q} + {{(SCORE_W+1-PTS_W){1'b0}}, pts2_q};
    assign w_sat1 = (w_sum1 > C_MAX_EXT) ? C_MAX : w_sum1[SCORE_W-1:0];
    assign w_sat2 = (w_sum2 > C_MAX_EXT) ? C_MAX : w_sum2[SCORE_W-1:0];

    assign w_p1_win = C_WIN_EN && (score1_q >= C_WIN);
    assign w_p2_win = C_WIN_EN && (score2_q >= C_WIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            score1_q <= '0;
            score2_q <= '0;
            winner_q <= WINNER_NONE;
            upd_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            score1_q <= score1_d;
            score2_q <= score2_d;
            winner_q <= winner_d;
            upd_q    <= (score1_d != score1_q) || (score2_d != score2_q);
        end
    end

    always_comb begin
        state_d  = state_q;
        score1_d = score1_q;
        score2_d = score2_q;
        winner_d = winner_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (w_start_ev) begin
                    state_d  = ST_PLAYING;
                    score1_d = '0;
                    score2_d = '0;
                    winner_d = WINNER_NONE;
                end
            end
            ST_PLAYING: begin
                // Once a winning score is visible the match closes; late hits are dropped.
                if (w_p1_win || w_p2_win) begin
                    state_d  = ST_OVER;
                    winner_d = {w_p2_win, w_p1_win};
                end else begin
                    if (w_hit1_ev) score1_d = w_sat1;
                    if (w_hit2_ev) score2_d = w_sat2;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign score1    = score1_q;
    assign score2    = score2_q;
    assign playing   = (state_q == ST_PLAYING);
    assign game_over = (state_q == ST_OVER);
    assign winner    = winner_q;
    assign score_upd = upd_q;

endmodule

`default_nettype wire
